module_control_display: RTL
===========================

# module_control_display

Sequential display controller for the Hamming decoder board. It latches each decode result (corrected-word segment code, error/syndrome segment code and the three status flags) on a valid strobe. It then time-multiplexes the latched codes onto a two-digit 7-segment display with active-low anodes, and blinks the error code on both digits when a double error is reported. It sits between the decoder and segment-code converters and the board pins, and replaces the static display-select mux at the top level.

## Interface
- REFRESH_CNT, default 50000: clock cycles per digit slot; minimum 2.
- BLINK_DIV, default 100: digit-slot periods per blink half-period; minimum 1.

- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- siete_seg  input  7  segment code of the corrected word (active-low segments)
- error  input  7  segment code of the error/syndrome ("E" on double error)
- error_simple  input  1  single error corrected
- error_doble  input  1  double error detected
- no_error  input  1  clean word
- swi  input  1  live user select for the undefined-flag case: 0 = word, 1 = error
- valido  input  1  one-cycle strobe, decode result valid this cycle
- seg  output  7  registered segment drive, active-low; blank = 7'h7F
- an  output  2  registered anode enables, active-low; an[0] = digit 0, an[1] = digit 1
- alerta  output  1  registered; 1 while in state DOBLE

## Operation
- Capture: when valido = 1 at a rising edge, cap_seg ← siete_seg, cap_err ← error, and the state is loaded. Flag precedence: error_doble → DOBLE; else error_simple → NORMAL with digit 1 showing the error code; else no_error → NORMAL with digit 1 blank; else INDEF.
- A valido in any state (including INICIO) recaptures. There is no busy period.
- States:
  - INICIO (reset): seg = 7'h7F, an = 2'b11. Leaves only on valido.
  - NORMAL: digit 0 = cap_seg. Digit 1 = cap_err (simple) or blank with its anode still driven (no_error).
  - DOBLE: both digits = cap_err while blink phase = 1. When blink phase = 0: an = 2'b11, seg = 7'h7F.
  - INDEF: digit 0 = (swi ? cap_err : cap_seg), with swi sampled live each cycle. Digit 1: an[1] = 1 in its slot (off), seg = 7'h7F.
- Refresh: ref_cnt counts 0..REFRESH_CNT-1 and wraps. On the wrap, dig_sel toggles. dig_sel = 0 drives an = 2'b10; dig_sel = 1 drives an = 2'b01, unless the state mandates 2'b11. ref_cnt and dig_sel run freely in every state and are never cleared by valido.
- Blink: blk_cnt advances on each ref_cnt wrap, counts 0..BLINK_DIV-1, and toggles blink phase on its wrap. Entering DOBLE from any other state clears blk_cnt and sets phase = 1. A recapture while already in DOBLE does not reset the blink.
- alerta = 1 exactly when the state is DOBLE.

## Timing
- Reset (async assert, removed synchronously by clk):
  - seg = 7'h7F, an = 2'b11, alerta = 0
  - state = INICIO
  - ref_cnt = 0, dig_sel = 0, blk_cnt = 0, phase = 1
  - cap_seg = cap_err = 7'h7F
- Latency: valido sampled at edge N updates state and capture registers at N. seg, an and alerta reflect the new data at edge N+1.
- Digit slot: exactly REFRESH_CNT cycles. The full display period is 2·REFRESH_CNT cycles.
- Blink half-period: exactly BLINK_DIV·REFRESH_CNT cycles.
- Changing swi in INDEF changes seg one edge later.
- Reset mid-operation returns all outputs to their reset values immediately, without waiting for a clock edge.
- Multiple flags high together resolve by precedence, never by a mix.

## Test plan
REFRESH_CNT = 4, BLINK_DIV = 2 for all scenarios.
1. Reset held, then released, no valido for 20 cycles → seg = 7'h7F, an = 2'b11, alerta = 0 throughout.
2. valido with no_error = 1, siete_seg = 7'h40 → one edge later an = 2'b10, seg = 7'h40. an alternates 2'b10/2'b01 every 4 cycles; in the digit 1 slot seg = 7'h7F.
3. valido with error_simple = 1, siete_seg = 7'h79, error = 7'h24 → seg alternates 7'h79 (an = 2'b10) and 7'h24 (an = 2'b01) every 4 cycles.
4. valido with error_doble = 1 and error_simple = 1, error = 7'h06 → alerta = 1. seg = 7'h06 on both digits for 8 cycles, then an = 2'b11 and seg = 7'h7F for 8 cycles, repeating.
5. valido with all flags 0, siete_seg = 7'h12, error = 7'h06 → with swi = 0, digit 0 shows 7'h12; toggling swi to 1 shows 7'h06 one edge later; digit 1 slot always has an = 2'b11.
6. rst asserted mid-DOBLE between clock edges → outputs return to their reset values immediately (seg = 7'h7F, an = 2'b11, alerta = 0); after release, the display stays blank until the next valido.

Source files
------------

// File: rtl/module_control_display_if.sv
// Decoder-result and display-pin bundle between the Hamming decoder datapath and
// the two-digit multiplexed display controller.
interface module_control_display_if;
  logic [6:0] siete_seg;
  logic [6:0] error;
  logic       error_simple;
  logic       error_doble;
  logic       no_error;
  logic       swi;
  logic       valido;
  logic [6:0] seg;
  logic [1:0] an;
  logic       alerta;

  modport master (
    output siete_seg, error, error_simple, error_doble, no_error, swi, valido,
    input  seg, an, alerta
  );

  modport slave (
    input  siete_seg, error, error_simple, error_doble, no_error, swi, valido,
    output seg, an, alerta
  );
endinterface

// File: rtl/module_control_display.sv
// Latches decode results on valido and time-multiplexes them onto a two-digit
// active-low 7-segment display, blinking the error code on a double error.
module module_control_display #(
  parameter int REFRESH_CNT = 50000,
  parameter int BLINK_DIV   = 100
) (
  input logic                      clk,
  input logic                      rst,
  module_control_display_if.slave  bus
);
  localparam int RW = $clog2(REFRESH_CNT);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {INICIO, NORMAL, DOBLE, INDEF} state_t;

  state_t        state, state_nxt;
  logic [6:0]    cap_seg, cap_err;
  logic          show_err;
  logic [RW-1:0] ref_cnt;
  logic          dig_sel;
  logic [BW-1:0] blk_cnt;
  logic          phase;
  logic          ref_wrap, enter_doble;
  logic [6:0]    seg_nxt;
  logic [1:0]    an_nxt;
  logic          alerta_nxt;

  assign ref_wrap    = (ref_cnt == RW'(REFRESH_CNT - 1));
  assign enter_doble = bus.valido && bus.error_doble && (state != DOBLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INICIO;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.valido) begin
      if (bus.error_doble)                         state_nxt = DOBLE;
      else if (bus.error_simple || bus.no_error)   state_nxt = NORMAL;
      else                                         state_nxt = INDEF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_seg  <= '1;
      cap_err  <= '1;
      show_err <= 1'b0;
    end else if (bus.valido) begin
      cap_seg  <= bus.siete_seg;
      cap_err  <= bus.error;
      show_err <= bus.error_simple;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      dig_sel <= 1'b0;
    end else if (ref_wrap) begin
      ref_cnt <= '0;
      dig_sel <= ~dig_sel;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Entry into DOBLE restarts the blink even if it coincides with a refresh wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt <= '0;
      phase   <= 1'b1;
    end else if (enter_doble) begin
      blk_cnt <= '0;
      phase   <= 1'b1;
    end else if (ref_wrap) begin
      if (blk_cnt == BW'(BLINK_DIV - 1)) begin
        blk_cnt <= '0;
        phase   <= ~phase;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    seg_nxt    = '1;
    an_nxt     = '1;
    alerta_nxt = (state == DOBLE);
    case (state)
      NORMAL: begin
        if (!dig_sel) begin
          an_nxt  = 2'b10;
          seg_nxt = cap_seg;
        end else begin
          an_nxt  = 2'b01;
          seg_nxt = show_err ? cap_err : 7'h7F;
        end
      end
      DOBLE: begin
        if (phase) begin
          an_nxt  = dig_sel ? 2'b01 : 2'b10;
          seg_nxt = cap_err;
        end
      end
      INDEF: begin
        if (!dig_sel) begin
          an_nxt  = 2'b10;
          seg_nxt = bus.swi ? cap_err : cap_seg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.seg    <= '1;
      bus.an     <= '1;
      bus.alerta <= 1'b0;
    end else begin
      bus.seg    <= seg_nxt;
      bus.an     <= an_nxt;
      bus.alerta <= alerta_nxt;
    end
  end
endmodule
